// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and the
// enable/disable levels used by the transmitter and receiver.
package uart_pkg;

  // Transmitter frame sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    UART_STATE_IDLE  = 2'd0,
    UART_STATE_START = 2'd1,
    UART_STATE_DATA  = 2'd2,
    UART_STATE_STOP  = 2'd3
  } uart_state_e;

  // Default bit period: 10 MHz system clock at 38400 baud.
  localparam int UART_DIV_RATE  = 260;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_CNT_W = 3;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted tx_start as
// start bit, 8 data bits LSB first, then 1 or 2 stop bits, each line level
// held DIV_RATE clocks. All outputs are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_RATE  = UART_DIV_RATE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_end,
  output logic       tx
);

  localparam int DIV_W = (DIV_RATE > 1) ? $clog2(DIV_RATE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATE - 1);
  localparam logic [UART_BIT_CNT_W-1:0] BIT_LAST = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

  uart_state_e                state_q;
  logic                       tx_q;
  logic                       tx_busy_q;
  logic                       tx_end_q;
  logic [7:0]                 shift_q;
  logic [DIV_W-1:0]           div_cnt_q;
  logic [DIV_W-1:0]           div_cnt_d;
  logic [UART_BIT_CNT_W-1:0]  bit_cnt_q;
  logic                       stop_cnt_q;
  logic                       div_wrap;
  logic                       stop_last;

  // Bit-period timer: wraps to 0 on the last clock of each line level; with
  // two stop bits a one-bit counter tells the first stop period from the last.
  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    stop_last = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;
  end

  // Frame sequencer with registered line, busy and end-of-frame outputs.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= UART_STATE_IDLE;
      tx_q       <= 1'b1;
      tx_busy_q  <= DISABLE;
      tx_end_q   <= DISABLE;
      shift_q    <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      // End-of-frame is a single-cycle pulse.
      tx_end_q <= DISABLE;
      case (state_q)
        UART_STATE_IDLE: begin
          tx_q      <= 1'b1;
          div_cnt_q <= '0;
          if (tx_start) begin
            shift_q   <= tx_data;
            state_q   <= UART_STATE_START;
            tx_q      <= 1'b0;
            tx_busy_q <= ENABLE;
          end
        end
        UART_STATE_START: begin
          div_cnt_q <= div_cnt_d;
          if (div_wrap) begin
            state_q   <= UART_STATE_DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        UART_STATE_DATA: begin
          div_cnt_q <= div_cnt_d;
          if (div_wrap) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q    <= UART_STATE_STOP;
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
            end else begin
              // Next bit is shift_q[1] before the shift lands.
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        UART_STATE_STOP: begin
          div_cnt_q <= div_cnt_d;
          tx_q      <= 1'b1;
          if (div_wrap) begin
            if (stop_last) begin
              state_q   <= UART_STATE_IDLE;
              tx_busy_q <= DISABLE;
              tx_end_q  <= ENABLE;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= UART_STATE_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;
  assign tx_end  = tx_end_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with one stop bit (unit 0) and one with two
// (unit 1), both at DIV_RATE=4, checked cycle by cycle against a frame model.
module tb_uart_tx;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_;
  logic [1:0] start;
  logic [7:0] data [2];
  logic [1:0] txo, busyo, endo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.DIV_RATE(D), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset_(reset_), .tx_start(start[0]), .tx_data(data[0]),
    .tx_busy(busyo[0]), .tx_end(endo[0]), .tx(txo[0])
  );

  uart_tx #(.DIV_RATE(D), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset_(reset_), .tx_start(start[1]), .tx_data(data[1]),
    .tx_busy(busyo[1]), .tx_end(endo[1]), .tx(txo[1])
  );

  // Reference model: a frame is a list of per-cycle line levels built from
  // the byte (start 0, data LSB first, stop 1s), played out one per clock;
  // tx_end fires the clock after the list runs out.
  int   rem [2] = '{0, 0};
  int   idx [2] = '{0, 0};
  logic lvl [2][64];
  logic [1:0] m_tx, m_busy, m_end;

  always @(posedge clk) begin
    int len, bp;
    for (int u = 0; u < 2; u++) begin
      len = (9 + u + 1) * D;
      if (!reset_) begin
        rem[u] = 0; m_tx[u] = 1'b1; m_busy[u] = 1'b0; m_end[u] = 1'b0;
      end else if (rem[u] == 0) begin
        m_tx[u] = 1'b1; m_busy[u] = 1'b0; m_end[u] = 1'b0;
        if (start[u]) begin
          for (int k = 0; k < len; k++) begin
            bp = k / D;
            if (bp == 0) lvl[u][k] = 1'b0;
            else if (bp <= 8) lvl[u][k] = data[u][bp-1];
            else lvl[u][k] = 1'b1;
          end
          rem[u] = len; idx[u] = 0;
          m_tx[u] = lvl[u][0]; m_busy[u] = 1'b1;
        end
      end else begin
        idx[u] = idx[u] + 1;
        rem[u] = rem[u] - 1;
        if (rem[u] == 0) begin
          m_tx[u] = 1'b1; m_busy[u] = 1'b0; m_end[u] = 1'b1;
        end else begin
          m_tx[u] = lvl[u][idx[u]];
        end
      end
    end
  end

  task automatic test_reset();
    reset_ = 1'b0; start = 2'b11;
    data[0] = 8'($urandom); data[1] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== 6'b11_00_00) begin
        n_bad++;
        $display("FAIL reset k=%0d tx/busy/end got %b %b %b want 11 00 00", k, txo, busyo, endo);
      end
    end
    reset_ = 1'b1; start = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== 6'b11_00_00) begin
        n_bad++;
        $display("FAIL reset_idle k=%0d tx/busy/end got %b %b %b want 11 00 00", k, txo, busyo, endo);
      end
    end
  endtask

  task automatic test_basic();
    logic ln [64];
    logic [39:0] got_lv, exp_lv;
    logic [7:0] dec;
    int busy_cnt = 0, ends = 0, end_at = -1;
    start[0] = 1'b1; data[0] = 8'h55;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL basic k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      ln[k] = txo[0];
      busy_cnt += int'(busyo[0]);
      if (endo[0]) begin ends++; end_at = k; end
    end
    for (int j = 0; j < 10; j++)
      for (int c = 0; c < D; c++) begin
        got_lv[j*D+c] = ln[j*D+c];
        exp_lv[j*D+c] = (j % 2 == 1);
      end
    for (int i = 0; i < 8; i++) dec[i] = ln[D*(1+i)+D/2];
    n_cmp++;
    if (got_lv !== exp_lv) begin n_bad++; $display("FAIL basic_levels got %h want %h", got_lv, exp_lv); end
    n_cmp++;
    if (busy_cnt != 40) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 40", busy_cnt); end
    n_cmp++;
    if (ends != 1 || end_at != 40) begin n_bad++; $display("FAIL basic_end got %0d pulses at %0d want 1 at 40", ends, end_at); end
    n_cmp++;
    if (dec !== 8'h55) begin n_bad++; $display("FAIL basic_decode got %h want 55", dec); end
  endtask

  task automatic test_ignore();
    logic ln [64];
    logic [7:0] dec;
    int ends = 0;
    start[0] = 1'b1; data[0] = 8'h55;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL ignore k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      ln[k] = txo[0];
      if (endo[0]) ends++;
      if (k == 0) start[0] = 1'b0;
      if (k == 10) begin start[0] = 1'b1; data[0] = 8'hFF; end
      if (k == 11) start[0] = 1'b0;
    end
    for (int i = 0; i < 8; i++) dec[i] = ln[D*(1+i)+D/2];
    n_cmp++;
    if (dec !== 8'h55) begin n_bad++; $display("FAIL ignore_decode got %h want 55", dec); end
    n_cmp++;
    if (ends != 1) begin n_bad++; $display("FAIL ignore_end_count got %0d want 1", ends); end
  endtask

  task automatic test_back_to_back();
    logic ln [100];
    logic [7:0] dec0, dec1;
    int ends = 0, end0 = -1, end1 = -1;
    start[0] = 1'b1; data[0] = 8'hA3;
    for (int k = 0; k < 95; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL b2b k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      ln[k] = txo[0];
      start[0] = 1'b0;
      if (endo[0]) begin
        ends++;
        if (ends == 1) begin end0 = k; start[0] = 1'b1; data[0] = 8'h0F; end
        else end1 = k;
      end
    end
    // Start requested in the tx_end cycle is taken at the next edge, so the
    // second start bit sits at cycle 41 and its frame ends at 81.
    for (int i = 0; i < 8; i++) begin
      dec0[i] = ln[D*(1+i)+D/2];
      dec1[i] = ln[41+D*(1+i)+D/2];
    end
    n_cmp++;
    if (end0 != 40 || end1 != 81) begin n_bad++; $display("FAIL b2b_end_times got %0d,%0d want 40,81", end0, end1); end
    n_cmp++;
    if (ln[41] !== 1'b0 || ln[40] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_start got %b%b want 10", ln[40], ln[41]); end
    n_cmp++;
    if ({dec0, dec1} !== 16'hA30F) begin n_bad++; $display("FAIL b2b_decode got %h %h want a3 0f", dec0, dec1); end
  endtask

  task automatic test_mid_reset();
    logic ln [64];
    logic [7:0] dec;
    int ends = 0, end_at = -1;
    start[0] = 1'b1; data[0] = 8'h5A;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL midrst k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      if (k == 18) begin
        n_cmp++;
        if (txo[0] !== 1'b1 || busyo[0] !== 1'b0) begin
          n_bad++; $display("FAIL midrst_abort tx/busy got %b %b want 1 0", txo[0], busyo[0]);
        end
      end
      if (endo[0]) ends++;
      if (k == 0) start[0] = 1'b0;
      if (k == 17) reset_ = 1'b0;
      if (k == 18) reset_ = 1'b1;
    end
    n_cmp++;
    if (ends != 0) begin n_bad++; $display("FAIL midrst_no_end got %0d pulses want 0", ends); end
    ends = 0;
    start[0] = 1'b1; data[0] = 8'h00;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL after_rst k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      ln[k] = txo[0];
      if (endo[0]) begin ends++; end_at = k; end
    end
    for (int i = 0; i < 8; i++) dec[i] = ln[D*(1+i)+D/2];
    n_cmp++;
    if (dec !== 8'h00 || ends != 1 || end_at != 40) begin
      n_bad++; $display("FAIL after_rst_frame got byte %h end %0d@%0d want 00 1@40", dec, ends, end_at);
    end
  endtask

  task automatic test_two_stop();
    logic ln [64];
    logic [7:0] dec;
    int busy_cnt = 0, ends = 0, end_at = -1, stop_hi = 0;
    start[1] = 1'b1; data[1] = 8'h80;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      if (k == 0) start[1] = 1'b0;
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL stop2 k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      ln[k] = txo[1];
      busy_cnt += int'(busyo[1]);
      if (endo[1]) begin ends++; end_at = k; end
    end
    for (int i = 0; i < 8; i++) dec[i] = ln[D*(1+i)+D/2];
    for (int k = 36; k < 44; k++) stop_hi += int'(ln[k] === 1'b1);
    n_cmp++;
    if (stop_hi != 8) begin n_bad++; $display("FAIL stop2_high got %0d cycles want 8", stop_hi); end
    n_cmp++;
    if (ends != 1 || end_at != 44 || busy_cnt != 44) begin
      n_bad++; $display("FAIL stop2_end got %0d@%0d busy %0d want 1@44 busy 44", ends, end_at, busy_cnt);
    end
    n_cmp++;
    if (dec !== 8'h80) begin n_bad++; $display("FAIL stop2_decode got %h want 80", dec); end
  endtask

  task automatic test_random();
    int dut_ends = 0, mdl_ends = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({txo, busyo, endo} !== {m_tx, m_busy, m_end}) begin
        n_bad++;
        $display("FAIL random k=%0d tx/busy/end got %b %b %b want %b %b %b", k, txo, busyo, endo, m_tx, m_busy, m_end);
      end
      dut_ends += int'(endo[0]) + int'(endo[1]);
      mdl_ends += int'(m_end[0]) + int'(m_end[1]);
      start[0] = ($urandom_range(0, 5) == 0) || endo[0];
      start[1] = ($urandom_range(0, 5) == 0);
      data[0] = 8'($urandom);
      data[1] = 8'($urandom);
    end
    start = 2'b00;
    n_cmp++;
    if (dut_ends != mdl_ends || mdl_ends < 10) begin
      n_bad++; $display("FAIL random_end_count got %0d want %0d (>=10)", dut_ends, mdl_ends);
    end
  endtask

  initial begin
    reset_ = 1'b0; start = 2'b00; data[0] = 8'h00; data[1] = 8'h00;
    test_reset();
    test_basic();
    repeat (5) @(negedge clk);
    test_ignore();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_mid_reset();
    repeat (5) @(negedge clk);
    test_two_stop();
    repeat (5) @(negedge clk);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
